// File: rtl/apv_event_arbiter.sv
// apv_event_arbiter: waits until every enabled APV channel FIFO holds a complete
// event, then drains the channels in ascending order onto one tagged
// valid/ready stream through a 2-entry skid buffer.
module apv_event_arbiter #(
  parameter int unsigned N_CH        = 16,
  parameter int unsigned FRAME_WORDS = 130,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  input  logic [N_CH-1:0]     CH_ENABLE,
  input  logic [4:0]          SAMPLE_PER_EVENT,
  input  logic [N_CH*12-1:0]  CH_USED_WORDS,
  input  logic [N_CH-1:0]     CH_FIFO_EMPTY,
  input  logic [N_CH*13-1:0]  CH_FIFO_DATA,
  output logic [N_CH-1:0]     CH_FIFO_RD,
  output logic [16:0]         OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_LAST,
  output logic                BUSY,
  output logic                EVENT_DONE,
  output logic [15:0]         EVENT_COUNT,
  output logic                TIMEOUT_ERR
);

  localparam int unsigned   CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned   TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_NEXT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [N_CH-1:0]     active_q, active_d;
  logic [11:0]         req_q, req_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic [11:0]         rem_q, rem_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic                to_err_q, to_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         event_count_q, event_count_d;
  logic                inf_q, inf_d;
  logic [CW-1:0]       inf_ch_q, inf_ch_d;
  logic                inf_last_q, inf_last_d;
  logic [1:0][16:0]    sk_data_q, sk_data_d;
  logic [1:0]          sk_last_q, sk_last_d;
  logic                sk_wr_q, sk_wr_d;
  logic                sk_rd_q, sk_rd_d;
  logic [1:0]          sk_occ_q, sk_occ_d;

  logic [N_CH-1:0]       ch_ready;
  logic [N_CH-1:0][12:0] ch_data;
  logic [4:0]            spe_eff;
  logic [11:0]           req_calc;
  logic                  all_ready, any_ready;
  logic [CW-1:0]         lowest, highest, next_ch;
  logic                  low_found, next_found;
  logic                  rd_go, pop;

  // Per-channel readiness, channel ordering and read-issue qualification.
  always_comb begin
    spe_eff  = (SAMPLE_PER_EVENT == 5'd0) ? 5'd1 : SAMPLE_PER_EVENT;
    req_calc = 12'(32'(spe_eff) * FRAME_WORDS);
    ch_ready = '0;
    ch_data  = '0;
    lowest     = '0;
    highest    = '0;
    next_ch    = '0;
    low_found  = 1'b0;
    next_found = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      ch_ready[c] = (CH_USED_WORDS[12*c +: 12] >= req_q);
      ch_data[c]  = CH_FIFO_DATA[13*c +: 13];
      if (active_q[c]) begin
        if (!low_found) begin
          lowest    = CW'(c);
          low_found = 1'b1;
        end
        highest = CW'(c);
        if (!next_found && (c > 32'(cur_q))) begin
          next_ch    = CW'(c);
          next_found = 1'b1;
        end
      end
    end
    all_ready = &(ch_ready | ~active_q);
    any_ready = |(ch_ready & active_q);
    // Budget counts buffered words plus the read whose data is still in flight.
    rd_go = (state_q == S_READ) && !CH_FIFO_EMPTY[cur_q] && (rem_q != 12'd0) &&
            (({1'b0, sk_occ_q} + {2'b00, inf_q}) < 3'd2);
    pop   = (sk_occ_q != 2'd0) && OUT_READY;
  end

  // Next-state for the sequencing FSM, timeout monitor and skid buffer.
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    req_d         = req_q;
    cur_d         = cur_q;
    rem_d         = rem_q;
    to_cnt_d      = '0;
    to_err_d      = to_err_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    event_count_d = event_count_q;
    inf_d         = rd_go;
    inf_ch_d      = cur_q;
    inf_last_d    = rd_go && (rem_q == 12'd1) && (cur_q == highest);
    sk_data_d     = sk_data_q;
    sk_last_d     = sk_last_q;
    sk_wr_d       = sk_wr_q;
    sk_rd_d       = sk_rd_q;
    sk_occ_d      = sk_occ_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (ENABLE && (|CH_ENABLE)) begin
          active_d = CH_ENABLE;
          req_d    = req_calc;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
        end else if (all_ready) begin
          busy_d  = 1'b1;
          cur_d   = lowest;
          rem_d   = req_q;
          state_d = S_READ;
        end else if (any_ready) begin
          if (to_cnt_q == TO_MAX) begin
            to_err_d = 1'b1;
            to_cnt_d = to_cnt_q;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      S_READ: begin
        if (rd_go) begin
          rem_d = rem_q - 12'd1;
          if (rem_q == 12'd1) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (next_found) begin
          cur_d   = next_ch;
          rem_d   = req_q;
          state_d = S_READ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((sk_occ_q == 2'd0) && !inf_q) begin
          done_d        = 1'b1;
          event_count_d = event_count_q + 16'd1;
          busy_d        = 1'b0;
          state_d       = ENABLE ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!ENABLE) to_err_d = 1'b0;

    if (pop) sk_rd_d = ~sk_rd_q;
    if (inf_q) begin
      sk_data_d[sk_wr_q] = {4'(inf_ch_q), ch_data[inf_ch_q]};
      sk_last_d[sk_wr_q] = inf_last_q;
      sk_wr_d            = ~sk_wr_q;
    end
    unique case ({inf_q, pop})
      2'b10:   sk_occ_d = sk_occ_q + 2'd1;
      2'b01:   sk_occ_d = sk_occ_q - 2'd1;
      default: sk_occ_d = sk_occ_q;
    endcase
  end

  // State registers; reset discards the skid buffer and any in-flight read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      active_q      <= '0;
      req_q         <= '0;
      cur_q         <= '0;
      rem_q         <= '0;
      to_cnt_q      <= '0;
      to_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      event_count_q <= '0;
      inf_q         <= 1'b0;
      inf_ch_q      <= '0;
      inf_last_q    <= 1'b0;
      sk_data_q     <= '0;
      sk_last_q     <= '0;
      sk_wr_q       <= 1'b0;
      sk_rd_q       <= 1'b0;
      sk_occ_q      <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      req_q         <= req_d;
      cur_q         <= cur_d;
      rem_q         <= rem_d;
      to_cnt_q      <= to_cnt_d;
      to_err_q      <= to_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      event_count_q <= event_count_d;
      inf_q         <= inf_d;
      inf_ch_q      <= inf_ch_d;
      inf_last_q    <= inf_last_d;
      sk_data_q     <= sk_data_d;
      sk_last_q     <= sk_last_d;
      sk_wr_q       <= sk_wr_d;
      sk_rd_q       <= sk_rd_d;
      sk_occ_q      <= sk_occ_d;
    end
  end

  assign CH_FIFO_RD  = rd_go ? (N_CH'(1) << cur_q) : '0;
  assign OUT_VALID   = (sk_occ_q != 2'd0);
  assign OUT_DATA    = sk_data_q[sk_rd_q];
  assign OUT_LAST    = OUT_VALID && sk_last_q[sk_rd_q];
  assign BUSY        = busy_q;
  assign EVENT_DONE  = done_q;
  assign EVENT_COUNT = event_count_q;
  assign TIMEOUT_ERR = to_err_q;

endmodule
